pc_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 39 +++
 rtl/pc_op_decode.sv | 20 ++
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcodes, next-PC mux selects, sequencer
// states and instruction classes.
package cpu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [1:0] PCS_SEQ  = 2'b00;
    localparam logic [1:0] PCS_BR   = 2'b01;
    localparam logic [1:0] PCS_JMP  = 2'b10;
    localparam logic [1:0] PCS_TRAP = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_BRANCH,
        ST_JUMP,
        ST_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_e;

endpackage

// File: rtl/pc_op_decode.sv
// Combinational opcode classifier; anything not explicitly recognised is
// reported as illegal so the sequencer can trap on it.
module pc_op_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode_i,
    output op_class_e  op_class_o
);

    always_comb begin
        unique case (opcode_i)
            OP_RTYPE, OP_ADDI: op_class_o = CLS_ALU;
            OP_LW, OP_SW:      op_class_o = CLS_MEM;
            OP_BEQ, OP_BNE:    op_class_o = CLS_BRANCH;
            OP_J, OP_JAL:      op_class_o = CLS_JUMP;
            default:           op_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle PC-update sequencer: owns PC/IR/EPC and the retired counter,
// and drives the select and load enable of the external next-PC mux.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        zero,
    input  logic [31:0] pc_next,
    output logic [1:0]  PCSource,
    output logic        pc_write,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [31:0] epc,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] retired_q, retired_d;
    op_class_e   op_class;
    logic        br_taken;

    pc_op_decode u_decode (
        .opcode_i   (ir_q[31:26]),
        .op_class_o (op_class)
    );

    assign br_taken = ((ir_q[31:26] == OP_BEQ) &&  zero) ||
                      ((ir_q[31:26] == OP_BNE) && !zero);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        ir_d      = ir_q;
        epc_d     = epc_q;
        retired_d = retired_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        pc_write  = 1'b0;
        PCSource  = PCS_SEQ;

        unique case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d     = imem_rdata;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                unique case (op_class)
                    CLS_ALU:    state_d = ST_EXEC;
                    CLS_MEM:    state_d = ST_MEM;
                    CLS_BRANCH: state_d = ST_BRANCH;
                    CLS_JUMP:   state_d = ST_JUMP;
                    default:    state_d = ST_TRAP;
                endcase
            end
            ST_EXEC: begin
                retired_d = retired_q + 32'd1;
                state_d   = ST_FETCH;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                PCSource  = PCS_BR;
                pc_write  = br_taken;
                retired_d = retired_q + 32'd1;
                state_d   = ST_FETCH;
            end
            ST_JUMP: begin
                PCSource  = PCS_JMP;
                pc_write  = 1'b1;
                retired_d = retired_q + 32'd1;
                state_d   = ST_FETCH;
            end
            ST_TRAP: begin
                // pc already points past the faulting instruction here.
                epc_d    = pc_q;
                PCSource = PCS_TRAP;
                pc_write = 1'b1;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        pc_d = pc_write ? pc_next : pc_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_VECTOR;
            ir_q      <= 32'h0;
            epc_q     <= 32'h0;
            retired_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            epc_q     <= epc_d;
            retired_q <= retired_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign epc       = epc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// instruction streams against an instruction-level architectural model.
module tb_pc_sequencer;

    localparam logic [31:0] TRAP_VEC = 32'h0000_0080;
    localparam int CLS_ALU = 0, CLS_MEM = 1, CLS_BR = 2, CLS_JMP = 3, CLS_ILL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_ack;
    logic        zero;
    logic [31:0] pc_next;
    logic [1:0]  PCSource;
    logic        pc_write;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] epc;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_pc, exp_ir, exp_epc, exp_ret;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_ack   (dmem_ack),
        .zero       (zero),
        .pc_next    (pc_next),
        .PCSource   (PCSource),
        .pc_write   (pc_write),
        .pc         (pc),
        .ir         (ir),
        .epc        (epc),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // External next-PC mux the sequencer steers.
    always_comb begin
        case (PCSource)
            2'b00:   pc_next = pc + 32'd4;
            2'b01:   pc_next = pc + {{14{ir[15]}}, ir[15:0], 2'b00};
            2'b10:   pc_next = {pc[31:28], ir[25:0], 2'b00};
            default: pc_next = TRAP_VEC;
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", tag, got, want);
        end
    endtask

    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'h00, 6'h08: return CLS_ALU;
            6'h23, 6'h2B: return CLS_MEM;
            6'h04, 6'h05: return CLS_BR;
            6'h02, 6'h03: return CLS_JMP;
            default:      return CLS_ILL;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_ir"}, ir, 32'h0);
        check({tag, "_epc"}, epc, 32'h0);
        check({tag, "_retired"}, retired, 32'h0);
        check({tag, "_pcsource"}, {30'h0, PCSource}, 32'h0);
        check({tag, "_pc_write"}, {31'h0, pc_write}, 32'h0);
        check({tag, "_dmem_req"}, {31'h0, dmem_req}, 32'h0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        exp_pc = 32'h0; exp_ir = 32'h0; exp_epc = 32'h0; exp_ret = 32'h0;
        #1 check("reset_release_imem_req", {31'h0, imem_req}, 32'h1);
    endtask

    task automatic preload_retired(input logic [31:0] v);
        force dut.retired_q = v;
        #1 release dut.retired_q;
        exp_ret = v;
        #1 check("preload_retired", retired, v);
    endtask

    // One full instruction starting at a negedge in FETCH.
    task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                             input logic z, input bit noise);
        int          cls, cyc, exp_cyc;
        logic        hold_ok;
        logic [31:0] a0, pc4;
        logic [1:0]  exp_pcs;
        logic        exp_pw;

        cls = op_class(instr[31:26]);
        pc4 = exp_pc + 32'd4;
        zero = z;
        check("fetch_imem_req", {31'h0, imem_req}, 32'h1);
        check("fetch_addr", imem_addr, exp_pc);
        check("fetch_pcsource", {30'h0, PCSource}, 32'h0);
        a0 = imem_addr;
        hold_ok = 1'b1;
        cyc = 0;
        repeat (iw) begin
            imem_ack = 1'b0; imem_rdata = $urandom;
            @(negedge clk); cyc++;
            if (imem_req !== 1'b1 || imem_addr !== a0 || pc_write !== 1'b0) hold_ok = 1'b0;
        end
        check("fetch_hold", {31'h0, hold_ok}, 32'h1);
        imem_ack = 1'b1; imem_rdata = instr;
        #1 check("fetch_pc_write", {31'h0, pc_write}, 32'h1);
        @(negedge clk); cyc++;
        imem_ack = 1'b0;

        if (noise) begin
            imem_ack = 1'b1; imem_rdata = $urandom; dmem_ack = 1'b1;
        end
        #1;
        check("decode_pc", pc, pc4);
        check("decode_ir", ir, instr);
        check("decode_pc_write", {31'h0, pc_write}, 32'h0);
        check("decode_imem_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk); cyc++;
        imem_ack = 1'b0; dmem_ack = 1'b0;

        exp_pcs = 2'b00; exp_pw = 1'b0;
        exp_ir  = instr;
        exp_pc  = pc4;
        exp_cyc = 3 + iw;
        case (cls)
            CLS_ALU: exp_ret = exp_ret + 32'd1;
            CLS_MEM: begin
                exp_ret = exp_ret + 32'd1;
                exp_cyc = exp_cyc + dw;
            end
            CLS_BR: begin
                exp_pcs = 2'b01;
                exp_pw  = (instr[31:26] == 6'h04) ? z : !z;
                if (exp_pw) exp_pc = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
                exp_ret = exp_ret + 32'd1;
            end
            CLS_JMP: begin
                exp_pcs = 2'b10; exp_pw = 1'b1;
                exp_pc  = {pc4[31:28], instr[25:0], 2'b00};
                exp_ret = exp_ret + 32'd1;
            end
            default: begin
                exp_pcs = 2'b11; exp_pw = 1'b1;
                exp_epc = pc4;
                exp_pc  = TRAP_VEC;
            end
        endcase

        if (cls == CLS_MEM) begin
            hold_ok = 1'b1;
            repeat (dw) begin
                if (dmem_req !== 1'b1 || pc_write !== 1'b0 || imem_req !== 1'b0) hold_ok = 1'b0;
                @(negedge clk); cyc++;
            end
            check("mem_req_hold", {31'h0, hold_ok & dmem_req}, 32'h1);
            dmem_ack = 1'b1;
            #1 check("mem_pc_write", {31'h0, pc_write}, 32'h0);
            @(negedge clk); cyc++;
            dmem_ack = 1'b0;
        end else begin
            #1;
            check("exec_pcsource", {30'h0, PCSource}, {30'h0, exp_pcs});
            check("exec_pc_write", {31'h0, pc_write}, {31'h0, exp_pw});
            @(negedge clk); cyc++;
        end

        check("latency", cyc, exp_cyc);
        check("done_pc", pc, exp_pc);
        check("done_ir", ir, exp_ir);
        check("done_epc", epc, exp_epc);
        check("done_retired", retired, exp_ret);
        check("done_dmem_req", {31'h0, dmem_req}, 32'h0);
    endtask

    initial begin
        logic [31:0] instr;
        logic [5:0]  legal_ops [8];
        legal_ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
        imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        apply_reset();

        run_instr(32'h2008_0001, 0, 0, 1'b0, 1'b0);
        check("addi_pc_is_4", pc, 32'h4);
        check("addi_retired_1", retired, 32'h1);
        run_instr(32'h1000_0003, 0, 0, 1'b1, 1'b0);
        run_instr(32'h1000_0003, 1, 0, 1'b0, 1'b0);
        run_instr(32'h1400_0002, 0, 0, 1'b1, 1'b1);
        run_instr(32'h0800_0040, 0, 0, 1'b0, 1'b0);
        check("jump_pc_0x100", pc, 32'h100);
        run_instr(32'h0800_0008, 0, 0, 1'b0, 1'b0);
        run_instr(32'hFC00_0000, 0, 0, 1'b0, 1'b0);
        check("trap_epc_0x24", epc, 32'h24);
        check("trap_pc_vector", pc, TRAP_VEC);
        run_instr(32'h8C00_0000, 2, 4, 1'b0, 1'b0);
        run_instr(32'hAC00_0004, 0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            instr = $urandom;
            if ($urandom_range(0, 4) != 0) instr[31:26] = legal_ops[$urandom_range(0, 7)];
            run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        preload_retired(32'hFFFF_FFFF);
        run_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0);
        check("retired_wrap", retired, 32'h0);

        preload_retired(32'hFFFF_FFFF);
        imem_ack = 1'b1; imem_rdata = 32'h8C00_0010;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_mem_dmem_req", {31'h0, dmem_req}, 32'h1);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_mem_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'h0; exp_ir = 32'h0; exp_epc = 32'h0; exp_ret = 32'h0;
        run_instr(32'h2008_0001, 0, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
